gf180mcu_osu_sc_gp9t3v3__oai21_bist: RTL and testbench

Built-in self-test sequencer for the OAI21 cell (Y = ~((A0 | A1) & B)), the product-of-sums complement of the library's AOI21.
- Drives all 8 input vectors into one OAI21 instance on the characterization test chip.
- Samples the cell output after a programmable settle time, compares it against the golden function, and reports a pass/fail verdict, mismatch count and first failing vector.
- Sits between the test-chip scan/control register and the cell under test, in the same clock domain.

---
 rtl/gf180mcu_osu_sc_bist_pkg.sv | 31 +++
 rtl/gf180mcu_osu_sc_gp9t3v3__bist_vecgen.sv | 58 +++++
 rtl/gf180mcu_osu_sc_gp9t3v3__oai21_bist.sv | 114 +++++++++++
 tb/tb_gf180mcu_osu_sc_gp9t3v3__oai21_bist.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_osu_sc_bist_pkg.sv
// Definitions shared by the standard-cell BIST sequencers: FSM states,
// the vector-to-pin mapping and the golden cell functions.
package gf180mcu_osu_sc_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } bist_state_t;

    localparam int VEC_W = 3;

    // Bit positions of each cell pin inside the 3-bit vector index.
    localparam int IDX_A0 = 2;
    localparam int IDX_A1 = 1;
    localparam int IDX_B  = 0;

    localparam logic [VEC_W-1:0] FIRST_IDX = 3'd0;
    localparam logic [VEC_W-1:0] LAST_IDX  = 3'd7;

    function automatic logic oai21_golden(input logic [VEC_W-1:0] vec);
        return ~((vec[IDX_A0] | vec[IDX_A1]) & vec[IDX_B]);
    endfunction

    function automatic logic aoi21_golden(input logic [VEC_W-1:0] vec);
        return ~((vec[IDX_A0] & vec[IDX_A1]) | vec[IDX_B]);
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp9t3v3__bist_vecgen.sv
// Vector sequencing counters for the cell BIST: vector index, sweep counter,
// settle down-counter and the flag marking the final vector of the final sweep.
module gf180mcu_osu_sc_gp9t3v3__bist_vecgen
    import gf180mcu_osu_sc_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             restart,
    input  logic             settle_load,
    input  logic             settle_step,
    input  logic             advance,
    output logic [VEC_W-1:0] idx,
    output logic             settle_done,
    output logic             last_vec
);

    // The counter is loaded with one less than the settle length because the
    // cycle in which it reaches zero is itself the final settle cycle.
    localparam logic [3:0] SETTLE_INIT = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [3:0] LAST_PASS   = 4'(PASSES - 1);

    logic [3:0] pcnt;
    logic [3:0] settle_cnt;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            idx  <= FIRST_IDX;
            pcnt <= 4'd0;
        end else if (restart) begin
            idx  <= FIRST_IDX;
            pcnt <= 4'd0;
        end else if (advance) begin
            if (idx == LAST_IDX) begin
                idx  <= FIRST_IDX;
                pcnt <= pcnt + 4'd1;
            end else begin
                idx <= idx + 3'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            settle_cnt <= 4'd0;
        end else if (settle_load) begin
            settle_cnt <= SETTLE_INIT;
        end else if (settle_step && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    assign settle_done = (settle_cnt == 4'd0);
    assign last_vec    = (idx == LAST_IDX) && (pcnt == LAST_PASS);

endmodule

// File: rtl/gf180mcu_osu_sc_gp9t3v3__oai21_bist.sv
// Built-in self-test sequencer for one OAI21 cell: sweeps all input vectors,
// compares the sampled output to the golden function and records the verdict.
module gf180mcu_osu_sc_gp9t3v3__oai21_bist
    import gf180mcu_osu_sc_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             Y_OBS,
    output logic             A0,
    output logic             A1,
    output logic             B,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [2:0]       FAIL_VEC,
    output logic             FAIL_SEEN
);

    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    bist_state_t      state;
    logic [VEC_W-1:0] idx;
    logic             settle_done;
    logic             last_vec;
    logic             start_ok;
    logic             mismatch;
    logic [CNT_W-1:0] err_next;

    assign start_ok = START && ((state == ST_IDLE) || (state == ST_DONE));
    assign mismatch = (state == ST_SAMPLE) && (Y_OBS != oai21_golden(idx));
    assign err_next = (mismatch && (ERR_CNT != ERR_MAX)) ? ERR_CNT + 1'b1 : ERR_CNT;

    gf180mcu_osu_sc_gp9t3v3__bist_vecgen #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .PASSES        (PASSES)
    ) u_vecgen (
        .CLK         (CLK),
        .RN          (RN),
        .restart     (start_ok),
        .settle_load (state == ST_APPLY),
        .settle_step (state == ST_SETTLE),
        .advance     ((state == ST_SAMPLE) && !last_vec),
        .idx         (idx),
        .settle_done (settle_done),
        .last_vec    (last_vec)
    );

    // The vector index is itself a register, so the cell pins come straight
    // off its flops and change on the same edge as the state.
    assign A0 = idx[IDX_A0];
    assign A1 = idx[IDX_A1];
    assign B  = idx[IDX_B];

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state     <= ST_IDLE;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_CNT   <= '0;
            FAIL_VEC  <= 3'd0;
            FAIL_SEEN <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state     <= ST_APPLY;
                        BUSY      <= 1'b1;
                        DONE      <= 1'b0;
                        PASS      <= 1'b0;
                        ERR_CNT   <= '0;
                        FAIL_VEC  <= 3'd0;
                        FAIL_SEEN <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    state <= (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_SAMPLE;
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    ERR_CNT <= err_next;
                    if (mismatch && !FAIL_SEEN) begin
                        FAIL_VEC  <= idx;
                        FAIL_SEEN <= 1'b1;
                    end
                    if (last_vec) begin
                        state <= ST_DONE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        PASS  <= (err_next == '0);
                    end else begin
                        state <= ST_APPLY;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__oai21_bist.sv
// Scoreboard bench for the OAI21 BIST: three parameterisations driven
// against a behavioural cell model with selectable faults.
module tb_gf180mcu_osu_sc_gp9t3v3__oai21_bist;

    typedef struct {
        int done_edge;
        int err;
        int fs;
        int fv;
        int pass;
    } result_t;

    logic       CLK = 1'b0;
    logic       RN;
    logic       start     [3];
    logic       y_obs     [3];
    logic       a0        [3];
    logic       a1        [3];
    logic       b         [3];
    logic       busy      [3];
    logic       done      [3];
    logic       pass_o    [3];
    logic       fail_seen [3];
    logic [2:0] fail_vec  [3];
    logic [3:0] err0;
    logic [3:0] err1;
    logic [1:0] err2;

    int fault_sel [3];
    int settle_of [3] = '{2, 0, 2};
    int passes_of [3] = '{1, 3, 2};
    int cntw_of   [3] = '{4, 4, 2};

    result_t sb[$];
    int tests_run    = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    // Fault modes: 0 ideal, 1 stuck-at-1, 2 stuck-at-0, 3 inverted on vector 6.
    function automatic logic cell_out(input int fault, input logic [2:0] v);
        logic ideal;
        ideal = ~((v[2] | v[1]) & v[0]);
        case (fault)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return (v == 3'd6) ? ~ideal : ideal;
            default: return ideal;
        endcase
    endfunction

    assign y_obs[0] = cell_out(fault_sel[0], {a0[0], a1[0], b[0]});
    assign y_obs[1] = cell_out(fault_sel[1], {a0[1], a1[1], b[1]});
    assign y_obs[2] = cell_out(fault_sel[2], {a0[2], a1[2], b[2]});

    gf180mcu_osu_sc_gp9t3v3__oai21_bist #(.SETTLE_CYCLES(2), .PASSES(1), .CNT_W(4)) dut (
        .CLK(CLK), .RN(RN), .START(start[0]), .Y_OBS(y_obs[0]),
        .A0(a0[0]), .A1(a1[0]), .B(b[0]), .BUSY(busy[0]), .DONE(done[0]), .PASS(pass_o[0]),
        .ERR_CNT(err0), .FAIL_VEC(fail_vec[0]), .FAIL_SEEN(fail_seen[0])
    );

    gf180mcu_osu_sc_gp9t3v3__oai21_bist #(.SETTLE_CYCLES(0), .PASSES(3), .CNT_W(4)) dut_p3 (
        .CLK(CLK), .RN(RN), .START(start[1]), .Y_OBS(y_obs[1]),
        .A0(a0[1]), .A1(a1[1]), .B(b[1]), .BUSY(busy[1]), .DONE(done[1]), .PASS(pass_o[1]),
        .ERR_CNT(err1), .FAIL_VEC(fail_vec[1]), .FAIL_SEEN(fail_seen[1])
    );

    gf180mcu_osu_sc_gp9t3v3__oai21_bist #(.SETTLE_CYCLES(2), .PASSES(2), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RN(RN), .START(start[2]), .Y_OBS(y_obs[2]),
        .A0(a0[2]), .A1(a1[2]), .B(b[2]), .BUSY(busy[2]), .DONE(done[2]), .PASS(pass_o[2]),
        .ERR_CNT(err2), .FAIL_VEC(fail_vec[2]), .FAIL_SEEN(fail_seen[2])
    );

    function automatic int err_of(input int u);
        case (u)
            0:       return int'(err0);
            1:       return int'(err1);
            default: return int'(err2);
        endcase
    endfunction

    function automatic int vec_of(input int u);
        return int'({a0[u], a1[u], b[u]});
    endfunction

    function automatic result_t model(input int u, input int fault);
        result_t r;
        int      max_cnt;
        int      golden;
        max_cnt = (1 << cntw_of[u]) - 1;
        r.err = 0;
        r.fs  = 0;
        r.fv  = 0;
        for (int p = 0; p < passes_of[u]; p++) begin
            for (int i = 0; i < 8; i++) begin
                golden = (i == 3 || i == 5 || i == 7) ? 0 : 1;
                if (int'(cell_out(fault, 3'(i))) != golden) begin
                    if (r.err < max_cnt) r.err++;
                    if (r.fs == 0) begin
                        r.fs = 1;
                        r.fv = i;
                    end
                end
            end
        end
        r.done_edge = 8 * passes_of[u] * (settle_of[u] + 2);
        r.pass      = (r.err == 0) ? 1 : 0;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Pushes the expected sweep outcome, then pulses START for one edge (edge k).
    task automatic applyStimulus(input int u, input int fault);
        fault_sel[u] = fault;
        sb.push_back(model(u, fault));
        @(negedge CLK);
        start[u] = 1'b1;
        @(posedge CLK);
        #1;
        start[u] = 1'b0;
        checkOutput("busy_at_k", int'(busy[u]), 1);
        checkOutput("done_at_k", int'(done[u]), 0);
        checkOutput("err_cleared", err_of(u), 0);
        checkOutput("fail_seen_cleared", int'(fail_seen[u]), 0);
        checkOutput("vec0_at_k", vec_of(u), 0);
    endtask

    // Follows the sweep edge by edge, optionally re-asserting START at edge
    // k+repulse, and compares the results against the scoreboard once DONE rises.
    task automatic collectResult(input int u, input int repulse);
        result_t exp_r;
        int      done_at;
        int      per;
        int      err_hold;
        per     = settle_of[u] + 2;
        done_at = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge CLK);
            #1;
            if (done[u]) begin
                done_at = n;
                break;
            end
            if (n % per == 0) checkOutput($sformatf("vec_at_k+%0d", n), vec_of(u), (n / per) % 8);
            start[u] = (n == repulse - 1) ? 1'b1 : 1'b0;
        end
        start[u] = 1'b0;
        if (done_at < 0) checkOutput("done_timeout", 0, 1);
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 1, 0);
        end else begin
            exp_r = sb.pop_front();
            checkOutput("done_edge", done_at, exp_r.done_edge);
            checkOutput("err_cnt", err_of(u), exp_r.err);
            checkOutput("fail_seen", int'(fail_seen[u]), exp_r.fs);
            checkOutput("fail_vec", int'(fail_vec[u]), exp_r.fv);
            checkOutput("pass", int'(pass_o[u]), exp_r.pass);
            checkOutput("busy_in_done", int'(busy[u]), 0);
            checkOutput("vec_hold_last", vec_of(u), 7);
        end
        err_hold = err_of(u);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("done_held", int'(done[u]), 1);
        checkOutput("err_held", err_of(u), err_hold);
    endtask

    // Starts a faulty sweep on the default instance and pulls RN low just after
    // edge k+17; every output must clear without waiting for a clock edge.
    task automatic rnAbort();
        fault_sel[0] = 1;
        @(negedge CLK);
        start[0] = 1'b1;
        @(posedge CLK);
        #1;
        start[0] = 1'b0;
        repeat (16) @(posedge CLK);
        #1;
        checkOutput("err_before_rn", err_of(0), 1);
        @(posedge CLK);
        #2;
        RN = 1'b0;
        #1;
        checkOutput("rn_vec", vec_of(0), 0);
        checkOutput("rn_busy", int'(busy[0]), 0);
        checkOutput("rn_done", int'(done[0]), 0);
        checkOutput("rn_err", err_of(0), 0);
        checkOutput("rn_fail_seen", int'(fail_seen[0]), 0);
        @(negedge CLK);
        RN = 1'b1;
        repeat (2) @(negedge CLK);
        checkOutput("rn_stays_idle", int'(busy[0]), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RN = 1'b0;
        for (int u = 0; u < 3; u++) begin
            start[u]     = 1'b0;
            fault_sel[u] = 0;
        end
        #12;
        for (int u = 0; u < 3; u++) begin
            checkOutput($sformatf("reset_vec_u%0d", u), vec_of(u), 0);
            checkOutput($sformatf("reset_busy_u%0d", u), int'(busy[u]), 0);
            checkOutput($sformatf("reset_done_u%0d", u), int'(done[u]), 0);
            checkOutput($sformatf("reset_pass_u%0d", u), int'(pass_o[u]), 0);
            checkOutput($sformatf("reset_err_u%0d", u), err_of(u), 0);
            checkOutput($sformatf("reset_fail_vec_u%0d", u), int'(fail_vec[u]), 0);
            checkOutput($sformatf("reset_fail_seen_u%0d", u), int'(fail_seen[u]), 0);
        end
        @(negedge CLK);
        RN = 1'b1;
        repeat (2) @(negedge CLK);
        checkOutput("idle_busy", int'(busy[0]), 0);

        applyStimulus(0, 0);
        collectResult(0, 0);
        applyStimulus(0, 1);
        collectResult(0, 0);
        applyStimulus(1, 3);
        collectResult(1, 0);
        applyStimulus(2, 2);
        collectResult(2, 0);
        applyStimulus(0, 0);
        collectResult(0, 10);
        applyStimulus(0, 1);
        collectResult(0, 0);
        applyStimulus(0, 0);
        collectResult(0, 0);

        rnAbort();
        applyStimulus(0, 0);
        collectResult(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
